// File: rtl/id_ex_reg_pkg.sv
// Shared core package: datapath width, ALU operation encoding and the
// decode/execute control bundle carried through the ID/EX register.
package id_ex_reg_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_SLL    = 4'h2,
        ALU_SLT    = 4'h3,
        ALU_SLTU   = 4'h4,
        ALU_XOR    = 4'h5,
        ALU_SRL    = 4'h6,
        ALU_SRA    = 4'h7,
        ALU_OR     = 4'h8,
        ALU_AND    = 4'h9,
        ALU_LUI    = 4'hA,
        ALU_PASS_B = 4'hB
    } alu_op_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    reg_wr_en;
        logic    dmem_rd;
        logic    dmem_wr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, reg_wr_en: 1'b0, dmem_rd: 1'b0, dmem_wr: 1'b0};

    // An empty decode slot must never carry live side effects into E.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
        return valid ? c : CTRL_NOP;
    endfunction

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use hazard detector: a load in E whose destination is read by the
// instruction in D must hold IF/ID for one cycle.
module load_use_detect (
    input  logic       valid_e,
    input  logic       dmem_rd_e,
    input  logic [4:0] rd_addr_e,
    input  logic       valid_d,
    input  logic [4:0] rs1_addr_d,
    input  logic [4:0] rs2_addr_d,
    input  logic       flush,
    output logic       load_use_stall
);

    logic src_match;

    assign src_match = (rd_addr_e == rs1_addr_d) | (rd_addr_e == rs2_addr_d);

    // x0 is hardwired zero, so a load targeting it creates no dependency.
    assign load_use_stall = valid_e & dmem_rd_e & (rd_addr_e != 5'd0)
                          & valid_d & src_match & ~flush;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush, stall and load-use bubble insertion,
// plus a saturating count of inserted bubbles.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int XLEN  = id_ex_reg_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [4:0]       rs1_addr_d,
    input  logic [4:0]       rs2_addr_d,
    input  logic [4:0]       rd_addr_d,
    input  logic [XLEN-1:0]  rs1_data_d,
    input  logic [XLEN-1:0]  rs2_data_d,
    input  logic [XLEN-1:0]  imm_d,
    input  logic [3:0]       alu_op_d,
    input  logic             reg_wr_en_d,
    input  logic             dmem_rd_d,
    input  logic             dmem_wr_d,
    output logic             valid_e,
    output logic [XLEN-1:0]  pc_e,
    output logic [4:0]       rs1_addr_e,
    output logic [4:0]       rs2_addr_e,
    output logic [4:0]       rd_addr_e,
    output logic [XLEN-1:0]  rs1_data_e,
    output logic [XLEN-1:0]  rs2_data_e,
    output logic [XLEN-1:0]  imm_e,
    output logic [3:0]       alu_op_e,
    output logic             reg_wr_en_e,
    output logic             dmem_rd_e,
    output logic             dmem_wr_e,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_e;
    logic  bubble;

    assign ctrl_d = '{alu_op:    alu_op_t'(alu_op_d),
                      reg_wr_en: reg_wr_en_d,
                      dmem_rd:   dmem_rd_d,
                      dmem_wr:   dmem_wr_d};

    load_use_detect u_load_use_detect (
        .valid_e        (valid_e),
        .dmem_rd_e      (ctrl_e.dmem_rd),
        .rd_addr_e      (rd_addr_e),
        .valid_d        (valid_d),
        .rs1_addr_d     (rs1_addr_d),
        .rs2_addr_d     (rs2_addr_d),
        .flush          (flush),
        .load_use_stall (load_use_stall)
    );

    // Flush beats stall; a load-use bubble only goes in when E is free to move.
    assign bubble = flush | (load_use_stall & ~stall);

    // NOTE: every stage register is reset here; this is a handful of flops,
    // not a memory array, and the hazard logic depends on valid_e being 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_e    <= 1'b0;
            pc_e       <= '0;
            rs1_addr_e <= '0;
            rs2_addr_e <= '0;
            rd_addr_e  <= '0;
            rs1_data_e <= '0;
            rs2_data_e <= '0;
            imm_e      <= '0;
            ctrl_e     <= CTRL_NOP;
            bubble_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            if (bubble) begin
                valid_e    <= 1'b0;
                pc_e       <= '0;
                rs1_addr_e <= '0;
                rs2_addr_e <= '0;
                rd_addr_e  <= '0;
                rs1_data_e <= '0;
                rs2_data_e <= '0;
                imm_e      <= '0;
                ctrl_e     <= CTRL_NOP;
            end else if (!stall) begin
                valid_e    <= valid_d;
                pc_e       <= pc_d;
                rs1_addr_e <= rs1_addr_d;
                rs2_addr_e <= rs2_addr_d;
                rd_addr_e  <= rd_addr_d;
                rs1_data_e <= rs1_data_d;
                rs2_data_e <= rs2_data_d;
                imm_e      <= imm_d;
                ctrl_e     <= gate_ctrl(ctrl_d, valid_d);
            end

            if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

    assign alu_op_e    = ctrl_e.alu_op;
    assign reg_wr_en_e = ctrl_e.reg_wr_en;
    assign dmem_rd_e   = ctrl_e.dmem_rd;
    assign dmem_wr_e   = ctrl_e.dmem_wr;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a reference model pushes the expected
// E-stage state per edge and a monitor pops and compares after each edge.
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rd;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        wr;
        logic        mrd;
        logic        mwr;
        logic [15:0] cnt;
        logic [1:0]  sat;
    } e_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, valid_d = 1'b0;
    logic [31:0] pc_d = '0, rs1_data_d = '0, rs2_data_d = '0, imm_d = '0;
    logic [4:0]  rs1_addr_d = '0, rs2_addr_d = '0, rd_addr_d = '0;
    logic [3:0]  alu_op_d = '0;
    logic        reg_wr_en_d = 1'b0, dmem_rd_d = 1'b0, dmem_wr_d = 1'b0;

    logic        valid_e, reg_wr_en_e, dmem_rd_e, dmem_wr_e, load_use_stall;
    logic [31:0] pc_e, rs1_data_e, rs2_data_e, imm_e;
    logic [4:0]  rs1_addr_e, rs2_addr_e, rd_addr_e;
    logic [3:0]  alu_op_e;
    logic [15:0] bubble_cnt;

    logic        s_valid_e, s_reg_wr_en_e, s_dmem_rd_e, s_dmem_wr_e, s_load_use_stall;
    logic [31:0] s_pc_e, s_rs1_data_e, s_rs2_data_e, s_imm_e;
    logic [4:0]  s_rs1_addr_e, s_rs2_addr_e, s_rd_addr_e;
    logic [3:0]  s_alu_op_e;
    logic [1:0]  s_bubble_cnt;

    int   tests_run = 0;
    int   failures  = 0;
    e_t   m;
    e_t   q[$];
    logic exp_lus;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_d(valid_d),
        .pc_d(pc_d), .rs1_addr_d(rs1_addr_d), .rs2_addr_d(rs2_addr_d), .rd_addr_d(rd_addr_d),
        .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .imm_d(imm_d), .alu_op_d(alu_op_d),
        .reg_wr_en_d(reg_wr_en_d), .dmem_rd_d(dmem_rd_d), .dmem_wr_d(dmem_wr_d),
        .valid_e(valid_e), .pc_e(pc_e), .rs1_addr_e(rs1_addr_e), .rs2_addr_e(rs2_addr_e),
        .rd_addr_e(rd_addr_e), .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e), .imm_e(imm_e),
        .alu_op_e(alu_op_e), .reg_wr_en_e(reg_wr_en_e), .dmem_rd_e(dmem_rd_e),
        .dmem_wr_e(dmem_wr_e), .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_reg #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_d(valid_d),
        .pc_d(pc_d), .rs1_addr_d(rs1_addr_d), .rs2_addr_d(rs2_addr_d), .rd_addr_d(rd_addr_d),
        .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .imm_d(imm_d), .alu_op_d(alu_op_d),
        .reg_wr_en_d(reg_wr_en_d), .dmem_rd_d(dmem_rd_d), .dmem_wr_d(dmem_wr_d),
        .valid_e(s_valid_e), .pc_e(s_pc_e), .rs1_addr_e(s_rs1_addr_e), .rs2_addr_e(s_rs2_addr_e),
        .rd_addr_e(s_rd_addr_e), .rs1_data_e(s_rs1_data_e), .rs2_data_e(s_rs2_data_e),
        .imm_e(s_imm_e), .alu_op_e(s_alu_op_e), .reg_wr_en_e(s_reg_wr_en_e),
        .dmem_rd_e(s_dmem_rd_e), .dmem_wr_e(s_dmem_wr_e), .load_use_stall(s_load_use_stall),
        .bubble_cnt(s_bubble_cnt)
    );

    // Scoreboard monitor: one expected record per edge that had stimulus pushed.
    always @(posedge clk) begin
        e_t exp_r;
        e_t obs;
        #1;
        if (q.size() > 0) begin
            exp_r = q.pop_front();
            obs = {valid_e, pc_e, rs1_addr_e, rs2_addr_e, rd_addr_e, rs1_data_e, rs2_data_e,
                   imm_e, alu_op_e, reg_wr_en_e, dmem_rd_e, dmem_wr_e, bubble_cnt, s_bubble_cnt};
            tests_run++;
            if (obs !== exp_r) begin
                failures++;
                $display("FAIL e_stage @%0t: got %h expected %h", $time, obs, exp_r);
            end
        end
    end

    // Drive one decode slot and, when push is set, advance the model and queue its result.
    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic wr,
                         input logic mrd, input logic mwr, input logic st, input logic fl,
                         input bit push = 1'b1);
        e_t   n;
        logic bub;
        valid_d = v; rs1_addr_d = rs1; rs2_addr_d = rs2; rd_addr_d = rd; imm_d = imm;
        reg_wr_en_d = wr; dmem_rd_d = mrd; dmem_wr_d = mwr; stall = st; flush = fl;
        pc_d = $urandom; rs1_data_d = $urandom; rs2_data_d = $urandom;
        alu_op_d = 4'($urandom_range(0, 11));
        exp_lus = m.valid & m.mrd & (m.rd != 5'd0) & v & ((m.rd == rs1) | (m.rd == rs2)) & ~fl;
        bub = fl | (exp_lus & ~st);
        n = m;
        if (bub) begin
            n = '0;
            n.cnt = m.cnt;
            n.sat = m.sat;
        end else if (!st) begin
            n.valid = v; n.pc = pc_d; n.rs1a = rs1; n.rs2a = rs2; n.rd = rd;
            n.rs1d = rs1_data_d; n.rs2d = rs2_data_d; n.imm = imm;
            n.alu_op = v ? alu_op_d : 4'd0;
            n.wr = v & wr; n.mrd = v & mrd; n.mwr = v & mwr;
        end
        if (bub && m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
        if (bub && m.sat != 2'd3)     n.sat = m.sat + 2'd1;
        if (push) begin
            q.push_back(n);
            m = n;
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reset pulse placed between edges; the model is cleared to match.
    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        m = '0;
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if ({valid_e, pc_e, rd_addr_e, imm_e, reg_wr_en_e, dmem_rd_e, bubble_cnt, load_use_stall} !== '0) begin
            failures++;
            $display("FAIL reset_async: outputs not zero before any edge, valid_e=%b cnt=%0d", valid_e, bubble_cnt);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        m = '0;
        tests_run++;
        if (valid_e !== 1'b0 || bubble_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_hold: valid_e=%b cnt=%0d expected 0/0", valid_e, bubble_cnt);
        end
    endtask

    task automatic test_plain();
        drive(1'b1, 5'd1, 5'd2, 5'd5, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (valid_e !== 1'b1 || rd_addr_e !== 5'd5 || imm_e !== 32'h10 || bubble_cnt !== 16'd0) begin
            failures++;
            $display("FAIL plain_flow: valid=%b rd=%0d imm=%h cnt=%0d expected 1/5/10/0",
                     valid_e, rd_addr_e, imm_e, bubble_cnt);
        end
        drive(1'b0, 5'd3, 5'd4, 5'd6, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if ({valid_e, reg_wr_en_e, dmem_rd_e, dmem_wr_e} !== 4'b0000) begin
            failures++;
            $display("FAIL invalid_ctrl: got %b expected 0000", {valid_e, reg_wr_en_e, dmem_rd_e, dmem_wr_e});
        end
    endtask

    task automatic test_load_use();
        logic [15:0] c0;
        drive(1'b1, 5'd1, 5'd2, 5'd7, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        c0 = m.cnt;
        drive(1'b1, 5'd3, 5'd7, 5'd8, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (load_use_stall !== 1'b1) begin
            failures++;
            $display("FAIL load_use_raise: got %b expected 1", load_use_stall);
        end
        tick();
        tests_run++;
        if (valid_e !== 1'b0 || reg_wr_en_e !== 1'b0 || bubble_cnt !== c0 + 16'd1 || load_use_stall !== 1'b0) begin
            failures++;
            $display("FAIL load_use_bubble: valid=%b wr=%b cnt=%0d lus=%b expected 0/0/%0d/0",
                     valid_e, reg_wr_en_e, bubble_cnt, load_use_stall, c0 + 16'd1);
        end
        drive(1'b1, 5'd3, 5'd7, 5'd8, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_load_x0();
        drive(1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd4, 5'd9, 32'h30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (load_use_stall !== 1'b0) begin
            failures++;
            $display("FAIL load_x0_lus: got %b expected 0", load_use_stall);
        end
        tick();
        tests_run++;
        if (valid_e !== 1'b1 || rd_addr_e !== 5'd9) begin
            failures++;
            $display("FAIL load_x0_capture: valid=%b rd=%0d expected 1/9", valid_e, rd_addr_e);
        end
    endtask

    task automatic test_stall_flush();
        logic [15:0] c0;
        logic [31:0] pc0;
        drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        c0 = m.cnt;
        drive(1'b1, 5'd1, 5'd2, 5'd6, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        tests_run++;
        if (valid_e !== 1'b0 || rd_addr_e !== 5'd0 || bubble_cnt !== c0 + 16'd1) begin
            failures++;
            $display("FAIL stall_flush: valid=%b rd=%0d cnt=%0d expected 0/0/%0d",
                     valid_e, rd_addr_e, bubble_cnt, c0 + 16'd1);
        end
        drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        pc0 = pc_e;
        c0  = bubble_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(i + 10), 5'(i + 20), 5'(i + 11), $urandom, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            tests_run++;
            if (rd_addr_e !== 5'd3 || pc_e !== pc0 || imm_e !== 32'h66 || bubble_cnt !== c0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: rd=%0d imm=%h cnt=%0d expected 3/66/%0d",
                         i, rd_addr_e, imm_e, bubble_cnt, c0);
            end
        end
    endtask

    task automatic test_stall_load_use();
        logic [15:0] c0;
        drive(1'b1, 5'd1, 5'd2, 5'd7, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        c0 = m.cnt;
        drive(1'b1, 5'd7, 5'd2, 5'd8, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tests_run++;
        if (load_use_stall !== 1'b1 || valid_e !== 1'b1 || rd_addr_e !== 5'd7 || bubble_cnt !== c0) begin
            failures++;
            $display("FAIL stall_load_use: lus=%b valid=%b rd=%0d cnt=%0d expected 1/1/7/%0d",
                     load_use_stall, valid_e, rd_addr_e, bubble_cnt, c0);
        end
        drive(1'b1, 5'd7, 5'd2, 5'd8, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (load_use_stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_masks_lus: got %b expected 0", load_use_stall);
        end
        tick();
        tests_run++;
        if (bubble_cnt !== c0 + 16'd1) begin
            failures++;
            $display("FAIL flush_load_use_once: cnt=%0d expected %0d", bubble_cnt, c0 + 16'd1);
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            tests_run++;
            if (s_bubble_cnt !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin
                failures++;
                $display("FAIL saturation[%0d]: cnt=%0d expected %0d", i, s_bubble_cnt, (i < 3) ? i + 1 : 3);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'd1, 5'd2, 5'd7, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd7, 5'd2, 5'd8, 32'h88, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        m = '0;
        tests_run++;
        if ({valid_e, pc_e, rd_addr_e, imm_e, reg_wr_en_e, dmem_rd_e, bubble_cnt, s_bubble_cnt, load_use_stall} !== '0) begin
            failures++;
            $display("FAIL async_reset: valid=%b rd=%0d cnt=%0d lus=%b expected all 0",
                     valid_e, rd_addr_e, bubble_cnt, load_use_stall);
        end
        #1 rst = 1'b0;
        drive(1'b1, 5'd7, 5'd2, 5'd8, 32'h88, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (valid_e !== 1'b1 || rd_addr_e !== 5'd8 || imm_e !== 32'h88 || bubble_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_release: valid=%b rd=%0d imm=%h cnt=%0d expected 1/8/88/0",
                     valid_e, rd_addr_e, imm_e, bubble_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m = '0;
        test_reset();
        test_plain();
        test_load_use();
        test_load_x0();
        test_stall_flush();
        test_stall_load_use();
        test_saturation();
        test_async_reset();
        tick();
        tests_run++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
